// File: rtl/tile_load_engine.sv
// -----------------------------------------------------------------------------
// tile_load_engine
//
// Shared load unit for LOAD_V and LOAD_M. It fetches one element at a time
// from the unified memory port and packs the elements into zero-padded,
// row-aligned tiles for the buffer controller. Matrix rows may be strided.
// The tile output has ready/valid backpressure. A command can be aborted; an
// abort that lands while a read is in flight waits for that read to return.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              one-cycle command strobe (only looked at in IDLE)
//   opcode             0x01 = LOAD_V, 0x02 = LOAD_M
//   dest_buffer_id     target buffer, echoed on tile_buffer_id
//   length_or_cols     vector length / matrix columns
//   rows               matrix rows (LOAD_V always uses one row)
//   row_stride         byte distance between row starts, 0 = dense
//   addr               base address
//   abort              cancel the current command
//   busy/done/error    status; error is only meaningful with done
//   mem_req/mem_addr   one-cycle read request
//   mem_rdata/mem_valid read return
//   tile_valid/tile_ready/tile_data/tile_buffer_id/tile_last  tile output
// -----------------------------------------------------------------------------
module tile_load_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int TILE_WIDTH = 256,
    parameter int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            opcode,
    input  logic [4:0]            dest_buffer_id,
    input  logic [9:0]            length_or_cols,
    input  logic [9:0]            rows,
    input  logic [ADDR_WIDTH-1:0] row_stride,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid,
    output logic                  tile_valid,
    input  logic                  tile_ready,
    output logic [TILE_WIDTH-1:0] tile_data,
    output logic [4:0]            tile_buffer_id,
    output logic                  tile_last
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH_REQ  = 3'd1;
    localparam logic [2:0] S_FETCH_WAIT = 3'd2;
    localparam logic [2:0] S_EMIT       = 3'd3;
    localparam logic [2:0] S_DRAIN      = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam logic [4:0] OP_LOAD_V = 5'h01;
    localparam logic [4:0] OP_LOAD_M = 5'h02;

    localparam int SLOT_W = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;

    logic [2:0]            r_state;
    logic                  r_error;
    logic [9:0]            r_cols;
    logic [9:0]            r_rows;
    logic [9:0]            r_row;
    logic [9:0]            r_col;
    logic [SLOT_W-1:0]     r_slot;
    logic [ADDR_WIDTH-1:0] r_stride;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [4:0]            r_buf_id;

    logic w_reject;
    logic w_row_done;
    logic w_is_last;
    logic w_fill_done;
    logic w_tile_clear;
    logic w_slot_write;

    assign w_reject = !((opcode == OP_LOAD_V) || (opcode == OP_LOAD_M))
                      || (length_or_cols == 10'd0)
                      || ((opcode == OP_LOAD_M) && (rows == 10'd0));

    // In EMIT, r_col has already been advanced past the last fetched element,
    // so "row finished" means it has reached the column count.
    assign w_row_done = (r_col == r_cols);
    assign w_is_last  = w_row_done && (r_row == r_rows - 10'd1);

    // Checked against the pre-increment slot/column of the element arriving now.
    assign w_fill_done = (r_slot == SLOT_W'(TILE_ELEMS - 1))
                         || (r_col == r_cols - 10'd1);

    // The tile is wiped whenever a fresh one begins, so padding slots read zero.
    assign w_tile_clear = ((r_state == S_IDLE) && start && !w_reject)
                          || ((r_state == S_EMIT) && tile_ready && !abort && !w_is_last);

    assign w_slot_write = (r_state == S_FETCH_WAIT) && mem_valid && !abort;

    // One register per slot; each only ever loads from the memory return.
    genvar gi;
    generate
        for (gi = 0; gi < TILE_ELEMS; gi++) begin : g_slot
            logic [DATA_WIDTH-1:0] r_elem;
            always_ff @(posedge clk) begin
                if (rst || w_tile_clear) begin
                    r_elem <= '0;
                end else if (w_slot_write && (r_slot == SLOT_W'(gi))) begin
                    r_elem <= mem_rdata;
                end
            end
            assign tile_data[gi*DATA_WIDTH +: DATA_WIDTH] = r_elem;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_error    <= 1'b0;
            r_cols     <= '0;
            r_rows     <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_slot     <= '0;
            r_stride   <= '0;
            r_row_base <= '0;
            r_buf_id   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_reject) begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_error    <= 1'b0;
                            r_buf_id   <= dest_buffer_id;
                            r_cols     <= length_or_cols;
                            r_rows     <= (opcode == OP_LOAD_M) ? rows : 10'd1;
                            // Zero stride means rows are packed back to back.
                            r_stride   <= ((opcode == OP_LOAD_M) && (row_stride != '0))
                                          ? row_stride : ADDR_WIDTH'(length_or_cols);
                            r_row      <= '0;
                            r_col      <= '0;
                            r_slot     <= '0;
                            r_row_base <= addr;
                            r_state    <= S_FETCH_REQ;
                        end
                    end
                end
                S_FETCH_REQ: begin
                    r_state <= abort ? S_IDLE : S_FETCH_WAIT;
                end
                S_FETCH_WAIT: begin
                    if (abort) begin
                        // If the read returns in the abort cycle there is nothing to drain.
                        r_state <= mem_valid ? S_IDLE : S_DRAIN;
                    end else if (mem_valid) begin
                        r_col   <= r_col + 10'd1;
                        r_slot  <= r_slot + SLOT_W'(1);
                        r_state <= w_fill_done ? S_EMIT : S_FETCH_REQ;
                    end
                end
                S_EMIT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (tile_ready) begin
                        if (w_is_last) begin
                            r_state <= S_DONE;
                        end else begin
                            if (w_row_done) begin
                                r_row_base <= r_row_base + r_stride;
                                r_row      <= r_row + 10'd1;
                                r_col      <= '0;
                            end
                            r_slot  <= '0;
                            r_state <= S_FETCH_REQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign error          = done && r_error;
    // Gating with abort/rst keeps a cancelled request off the bus entirely.
    assign mem_req        = (r_state == S_FETCH_REQ) && !abort && !rst;
    assign mem_addr       = r_row_base + ADDR_WIDTH'(r_col);
    assign tile_valid     = (r_state == S_EMIT) && !abort;
    assign tile_last      = tile_valid && w_is_last;
    assign tile_buffer_id = r_buf_id;

endmodule

// File: tb/tb_tile_load_engine.sv
module tb_tile_load_engine;

    localparam int DW = 8;
    localparam int TW = 256;
    localparam int TE = TW / DW;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [4:0]    opcode = '0;
    logic [4:0]    dest_buffer_id = '0;
    logic [9:0]    length_or_cols = '0;
    logic [9:0]    rows = '0;
    logic [AW-1:0] row_stride = '0;
    logic [AW-1:0] addr = '0;
    logic          abort = 1'b0;
    logic          busy, done, error, mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_valid = 1'b0;
    logic          tile_valid;
    logic          tile_ready = 1'b0;
    logic [TW-1:0] tile_data;
    logic [4:0]    tile_buffer_id;
    logic          tile_last;

    tile_load_engine #(.DATA_WIDTH(DW), .TILE_WIDTH(TW), .TILE_ELEMS(TE), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .dest_buffer_id(dest_buffer_id), .length_or_cols(length_or_cols),
        .rows(rows), .row_stride(row_stride), .addr(addr), .abort(abort),
        .busy(busy), .done(done), .error(error), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_data(tile_data),
        .tile_buffer_id(tile_buffer_id), .tile_last(tile_last)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;        // memory latency in cycles
    int rdy_mode = 0;   // 0: tile_ready held by main, 1: random
    int start_cyc = 0;

    // observation
    logic [AW-1:0] obs_addr_q [$];
    int            obs_req_cyc_q [$];
    logic [TW-1:0] obs_tile_q [$];
    bit            obs_last_q [$];
    logic [4:0]    obs_bid_q [$];
    int            obs_acc_cyc_q [$];
    int            done_cnt = 0;
    bit            done_err = 1'b0;
    int            done_cyc = 0;
    int            tv_cnt = 0;
    int            proto_err = 0;
    int            overlap_err = 0;

    // reference model output
    logic [AW-1:0] exp_addr_q [$];
    logic [TW-1:0] exp_tile_q [$];
    bit            exp_last_q [$];
    bit            exp_err;

    typedef struct {
        logic [4:0]    op;
        int            cols;
        int            nrows;
        logic [AW-1:0] stride;
        logic [AW-1:0] base;
        logic [4:0]    bid;
        int            lat;
        int            rdy;
        bit            err;
        int            tiles;
        int            reads;
    } vec_t;

    vec_t vecs [11];

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // Memory: one response per request, fixed latency, data derived from address.
    initial begin
        logic [AW-1:0] a;
        int l;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                a = mem_addr;
                l = lat;
                obs_addr_q.push_back(a);
                obs_req_cyc_q.push_back(cyc);
                for (int i = 0; i < l - 1; i++) begin
                    @(negedge clk);
                    if (mem_req === 1'b1) overlap_err++;
                end
                @(posedge clk);
                #1;
                mem_valid = 1'b1;
                mem_rdata = mem_byte(a);
                @(negedge clk);
                if (mem_req === 1'b1) overlap_err++;
                @(posedge clk);
                #1;
                mem_valid = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) tile_ready = ($urandom_range(0, 3) != 0);
    end

    // Output monitor: handshakes, done pulses and protocol rules.
    initial begin
        bit            prev_stall = 1'b0;
        logic [TW-1:0] prev_data = '0;
        bit            prev_last = 1'b0;
        logic [4:0]    prev_bid = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tile_valid) tv_cnt++;
                if (tile_valid && tile_ready) begin
                    obs_tile_q.push_back(tile_data);
                    obs_last_q.push_back(tile_last);
                    obs_bid_q.push_back(tile_buffer_id);
                    obs_acc_cyc_q.push_back(cyc);
                end
                if (done) begin
                    done_cnt++;
                    done_err = error;
                    done_cyc = cyc;
                end
                if (error && !done) proto_err++;
                if (mem_req && tile_valid) proto_err++;
                if (prev_stall && tile_valid &&
                    (tile_data !== prev_data || tile_last !== prev_last || tile_buffer_id !== prev_bid))
                    proto_err++;
            end
            prev_stall = tile_valid && !tile_ready;
            prev_data  = tile_data;
            prev_last  = tile_last;
            prev_bid   = tile_buffer_id;
        end
    end

    // Reference model: enumerate rows, then tiles within a row, then slots.
    task automatic build_model(input logic [4:0] op, input int cols, input int nrows_in,
                               input logic [AW-1:0] stride, input logic [AW-1:0] base);
        int nr, ntile, c;
        longint st;
        logic [AW-1:0] a;
        logic [TW-1:0] t;
        exp_addr_q.delete();
        exp_tile_q.delete();
        exp_last_q.delete();
        exp_err = !(op == 5'h01 || op == 5'h02) || cols == 0 || (op == 5'h02 && nrows_in == 0);
        if (!exp_err) begin
            nr    = (op == 5'h01) ? 1 : nrows_in;
            st    = (op == 5'h02 && stride != 0) ? longint'(stride) : longint'(cols);
            ntile = (cols + TE - 1) / TE;
            for (int r = 0; r < nr; r++) begin
                for (int k = 0; k < ntile; k++) begin
                    t = '0;
                    for (int j = 0; j < TE; j++) begin
                        c = k * TE + j;
                        if (c < cols) begin
                            a = AW'(longint'(base) + longint'(r) * st + longint'(c));
                            exp_addr_q.push_back(a);
                            t[j*DW +: DW] = mem_byte(a);
                        end
                    end
                    exp_tile_q.push_back(t);
                    exp_last_q.push_back(r == nr - 1 && k == ntile - 1);
                end
            end
        end
    endtask

    task automatic issue(input logic [4:0] op, input int cols, input int nrows_in,
                         input logic [AW-1:0] stride, input logic [AW-1:0] base, input logic [4:0] bid);
        obs_addr_q.delete();
        obs_req_cyc_q.delete();
        obs_tile_q.delete();
        obs_last_q.delete();
        obs_bid_q.delete();
        obs_acc_cyc_q.delete();
        done_cnt = 0;
        tv_cnt = 0;
        build_model(op, cols, nrows_in, stride, base);
        tick();
        opcode = op;
        length_or_cols = 10'(cols);
        rows = 10'(nrows_in);
        row_stride = stride;
        addr = base;
        dest_buffer_id = bid;
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        int budget = 100 + exp_addr_q.size() * (lat + 2) * 3 + exp_tile_q.size() * 40;
        while (done_cnt == 0 && n < budget) begin
            sample();
            n++;
        end
        check($sformatf("%s.done_count", tag), done_cnt, 1);
        sample();
        check($sformatf("%s.busy_after_done", tag), busy, 0);
        check($sformatf("%s.single_done", tag), done_cnt, 1);
    endtask

    task automatic compare(input string tag, input logic [4:0] bid, input int tbl_tiles, input int tbl_reads);
        int n;
        check($sformatf("%s.error", tag), done_err, exp_err);
        check($sformatf("%s.reads", tag), obs_addr_q.size(), exp_addr_q.size());
        check($sformatf("%s.tiles", tag), obs_tile_q.size(), exp_tile_q.size());
        if (tbl_tiles >= 0) begin
            check($sformatf("%s.tiles_tbl", tag), obs_tile_q.size(), tbl_tiles);
            check($sformatf("%s.reads_tbl", tag), obs_addr_q.size(), tbl_reads);
        end
        n = (obs_addr_q.size() < exp_addr_q.size()) ? obs_addr_q.size() : exp_addr_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.addr%0d", tag, i), obs_addr_q[i], exp_addr_q[i]);
        n = (obs_tile_q.size() < exp_tile_q.size()) ? obs_tile_q.size() : exp_tile_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s.tile%0d", tag, i), obs_tile_q[i], exp_tile_q[i]);
            check($sformatf("%s.last%0d", tag, i), obs_last_q[i], exp_last_q[i]);
            check($sformatf("%s.bid%0d", tag, i), obs_bid_q[i], bid);
        end
        if (exp_err) begin
            check($sformatf("%s.reject_latency", tag), done_cyc - start_cyc, 1);
        end else begin
            if (obs_req_cyc_q.size() > 0)
                check($sformatf("%s.first_req_latency", tag), obs_req_cyc_q[0] - start_cyc, 1);
            if (obs_acc_cyc_q.size() > 0)
                check($sformatf("%s.done_after_last", tag), done_cyc - obs_acc_cyc_q[obs_acc_cyc_q.size()-1], 1);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [4:0] op, input int cols, input int nrows_in,
                           input logic [AW-1:0] stride, input logic [AW-1:0] base, input logic [4:0] bid,
                           input int tbl_tiles, input int tbl_reads);
        issue(op, cols, nrows_in, stride, base, bid);
        wait_done(tag);
        compare(tag, bid, tbl_tiles, tbl_reads);
        $display("cmd %s op=%0h cols=%0d rows=%0d stride=%0h addr=%0h reads=%0d tiles=%0d err=%0d",
                 tag, op, cols, nrows_in, stride, base, obs_addr_q.size(), obs_tile_q.size(), done_err);
    endtask

    initial begin
        logic [TW-1:0] held;
        bit            held_last;
        int            nreq, n;
        logic [4:0]    r_op;

        vecs[0]  = '{5'h01, 40, 0, 24'h0,  24'h000100, 5'd3,  1, 0, 1'b0, 2, 40};
        vecs[1]  = '{5'h02, 5,  3, 24'h8,  24'h000040, 5'd1,  1, 0, 1'b0, 3, 15};
        vecs[2]  = '{5'h02, 5,  3, 24'h0,  24'h000040, 5'd2,  1, 0, 1'b0, 3, 15};
        vecs[3]  = '{5'h03, 8,  1, 24'h0,  24'h000080, 5'd4,  1, 0, 1'b1, 0, 0};
        vecs[4]  = '{5'h01, 0,  1, 24'h0,  24'h000080, 5'd5,  1, 0, 1'b1, 0, 0};
        vecs[5]  = '{5'h02, 4,  0, 24'h0,  24'h000080, 5'd6,  1, 0, 1'b1, 0, 0};
        vecs[6]  = '{5'h00, 4,  1, 24'h0,  24'h000080, 5'd6,  1, 0, 1'b1, 0, 0};
        vecs[7]  = '{5'h02, 33, 2, 24'h40, 24'hFFFFF0, 5'd7,  2, 1, 1'b0, 4, 66};
        vecs[8]  = '{5'h01, 32, 0, 24'h0,  24'h001000, 5'd8,  3, 1, 1'b0, 1, 32};
        vecs[9]  = '{5'h01, 1,  7, 24'h5,  24'h002000, 5'd9,  1, 1, 1'b0, 1, 1};
        vecs[10] = '{5'h02, 64, 2, 24'd100, 24'h003000, 5'd10, 2, 1, 1'b0, 4, 128};

        // reset state
        repeat (3) tick();
        sample();
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.error", error, 0);
        check("rst.mem_req", mem_req, 0);
        check("rst.tile_valid", tile_valid, 0);
        check("rst.tile_last", tile_last, 0);
        check("rst.mem_addr", mem_addr, 0);
        check("rst.tile_data", tile_data, 0);
        check("rst.tile_buffer_id", tile_buffer_id, 0);
        tick();
        rst = 1'b0;

        for (int v = 0; v < 11; v++) begin
            lat = vecs[v].lat;
            if (vecs[v].rdy == 1) begin
                rdy_mode = 1;
            end else begin
                rdy_mode = 0;
                tile_ready = 1'b1;
            end
            run_cmd($sformatf("vec%0d", v), vecs[v].op, vecs[v].cols, vecs[v].nrows, vecs[v].stride,
                    vecs[v].base, vecs[v].bid, vecs[v].tiles, vecs[v].reads);
            check($sformatf("vec%0d.err_tbl", v), done_err, vecs[v].err);
        end

        // backpressure on the first tile
        lat = 1;
        rdy_mode = 0;
        tile_ready = 1'b0;
        issue(5'h01, 40, 0, 24'h0, 24'h000100, 5'd11);
        n = 0;
        while (!tile_valid && n < 500) begin
            sample();
            n++;
        end
        check("bp.valid_seen", tile_valid, 1);
        held = tile_data;
        held_last = tile_last;
        nreq = obs_addr_q.size();
        for (int i = 0; i < 5; i++) begin
            tick();
            sample();
            check($sformatf("bp.valid%0d", i), tile_valid, 1);
            check($sformatf("bp.data%0d", i), tile_data, held);
            check($sformatf("bp.last%0d", i), tile_last, held_last);
            check($sformatf("bp.mem_req%0d", i), mem_req, 0);
            check($sformatf("bp.reqs%0d", i), obs_addr_q.size(), nreq);
        end
        tick();
        tile_ready = 1'b1;
        sample();
        tick();
        sample();
        check("bp.resume_req", mem_req, 1);
        wait_done("bp");
        compare("bp", 5'd11, 2, 40);
        $display("cmd bp stall=5 reads=%0d tiles=%0d", obs_addr_q.size(), obs_tile_q.size());

        // abort while a read is outstanding
        lat = 4;
        tile_ready = 1'b1;
        issue(5'h01, 40, 0, 24'h0, 24'h000200, 5'd4);
        n = 0;
        while (obs_addr_q.size() == 0 && n < 50) begin
            sample();
            n++;
        end
        check("abort.req_seen", obs_addr_q.size(), 1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("abort.busy%0d", i), busy, 1);
        end
        sample();
        check("abort.idle", busy, 0);
        repeat (4) sample();
        check("abort.no_done", done_cnt, 0);
        check("abort.no_tile_valid", tv_cnt, 0);
        check("abort.reads", obs_addr_q.size(), 1);
        $display("cmd abort reads=%0d tiles=%0d done=%0d", obs_addr_q.size(), tv_cnt, done_cnt);
        lat = 1;
        run_cmd("after_abort", 5'h01, 4, 0, 24'h0, 24'h000300, 5'd5, 1, 4);

        // reset mid-command with a slow memory
        lat = 4;
        issue(5'h02, 5, 2, 24'h0, 24'h000500, 5'd7);
        n = 0;
        while (obs_addr_q.size() < 3 && n < 100) begin
            sample();
            n++;
        end
        check("mrst.reqs_before", obs_addr_q.size(), 3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        check("mrst.busy", busy, 0);
        check("mrst.done", done, 0);
        check("mrst.error", error, 0);
        check("mrst.mem_req", mem_req, 0);
        check("mrst.tile_valid", tile_valid, 0);
        check("mrst.tile_last", tile_last, 0);
        check("mrst.mem_addr", mem_addr, 0);
        check("mrst.tile_data", tile_data, 0);
        check("mrst.tile_buffer_id", tile_buffer_id, 0);
        repeat (6) sample();
        check("mrst.still_idle", busy, 0);
        check("mrst.no_done", done_cnt, 0);
        check("mrst.reads", obs_addr_q.size(), 3);
        $display("cmd midreset reads=%0d done=%0d", obs_addr_q.size(), done_cnt);
        run_cmd("after_rst", 5'h02, 5, 2, 24'h0, 24'h000600, 5'd8, 2, 10);

        // randomized commands
        for (int k = 0; k < 8; k++) begin
            lat = $urandom_range(1, 3);
            rdy_mode = 1;
            r_op = ($urandom_range(0, 9) == 0) ? 5'h03 : (($urandom_range(0, 1) == 0) ? 5'h01 : 5'h02);
            run_cmd($sformatf("rnd%0d", k), r_op, $urandom_range(1, 70), $urandom_range(1, 4),
                    ($urandom_range(0, 1) == 0) ? 24'h0 : AW'($urandom_range(1, 200)),
                    AW'($urandom), 5'($urandom), -1, -1);
        end
        rdy_mode = 0;

        check("protocol_violations", proto_err, 0);
        check("overlapping_reads", overlap_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
